// File: rtl/alu_result_stage.sv
// alu_result_stage
// ----------------
// Buffers ALU results (Z, flags, destination tag) in a small in-order FIFO
// between the ALU and its consumer. The stage also raises a one-cycle trap
// for overflowing signed results, and it keeps sticky status flags.
//
// Parameters
//   DEPTH         number of result-buffer entries (power of two, >= 2)
//
// Ports
//   clk           single clock; all state updates on the rising edge
//   rst           synchronous, active-high reset
//   in_valid      ALU result present this cycle
//   in_ready      stage can accept a result (does not depend on out_ready)
//   in_z          ALU result
//   in_overflow   ALU overflow flag
//   in_zero       ALU zero flag
//   in_carryout   ALU carry-out flag
//   in_rd         destination register tag
//   in_trap_en    overflow on this result raises a trap instead of storing
//   out_valid     head entry available
//   out_ready     consumer accepts the head entry
//   out_z, out_overflow, out_zero, out_carryout, out_rd
//                 fields of the head entry (0 while the buffer is empty)
//   trap          one-cycle pulse for a trapped result
//   trap_rd       tag of the most recent trapped result
//   status_clr    clears the sticky status bits
//   status        sticky {overflow, carryout, zero-seen}

module alu_result_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_z,
  input  logic        in_overflow,
  input  logic        in_zero,
  input  logic        in_carryout,
  input  logic [4:0]  in_rd,
  input  logic        in_trap_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_z,
  output logic        out_overflow,
  output logic        out_zero,
  output logic        out_carryout,
  output logic [4:0]  out_rd,
  output logic        trap,
  output logic [4:0]  trap_rd,
  input  logic        status_clr,
  output logic [2:0]  status
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("alu_result_stage: DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic [31:0] z;
    logic        overflow;
    logic        zero;
    logic        carryout;
    logic [4:0]  rd;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             wr_entry;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               trap_hit;
  logic               store;
  logic               trap_q;
  logic [4:0]         trap_rd_q;
  logic [2:0]         status_q;
  logic [2:0]         status_set;

  // Ready comes from occupancy only, never from out_ready: a full buffer
  // refuses a push even in a cycle that pops.
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !rst && !full;
  assign out_valid = !rst && !empty;

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign trap_hit = push && in_overflow && in_trap_en;
  assign store    = push && !trap_hit;

  // Writes to r0 are architecturally zero; the arithmetic flags still
  // describe the operation, so they are kept as they arrived.
  always_comb begin
    wr_entry          = '0;
    wr_entry.z        = (in_rd == 5'd0) ? 32'd0 : in_z;
    wr_entry.zero     = (in_rd == 5'd0) ? 1'b1  : in_zero;
    wr_entry.overflow = in_overflow;
    wr_entry.carryout = in_carryout;
    wr_entry.rd       = in_rd;
  end

  // Status uses the raw flags, including trapped and r0 results.
  assign status_set = push ? {in_overflow, in_carryout, in_zero} : 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      trap_q    <= 1'b0;
      trap_rd_q <= 5'd0;
      status_q  <= 3'b000;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (store) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({store, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      trap_q <= trap_hit;
      if (trap_hit) begin
        trap_rd_q <= in_rd;
      end

      // A set in the same cycle as a clear wins.
      status_q <= (status_clr ? 3'b000 : status_q) | status_set;
    end
  end

  assign head = mem[rd_ptr];

  // Outputs read as zero while empty or in reset so nothing stale leaks out.
  assign out_z        = out_valid ? head.z        : 32'd0;
  assign out_overflow = out_valid ? head.overflow : 1'b0;
  assign out_zero     = out_valid ? head.zero     : 1'b0;
  assign out_carryout = out_valid ? head.carryout : 1'b0;
  assign out_rd       = out_valid ? head.rd       : 5'd0;

  assign trap    = !rst && trap_q;
  assign trap_rd = rst ? 5'd0 : trap_rd_q;
  assign status  = rst ? 3'b000 : status_q;

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: DEPTH, default 2, result-buffer entries; SHALL be a power of two >= 2.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  ALU result present this cycle.
REQ-005 Port: in_ready  output  1  stage can accept a result this cycle.
REQ-006 Port: in_z  input  32  ALU result Z.
REQ-007 Port: in_overflow / in_zero / in_carryout  input  1 each  ALU flags.
REQ-008 Port: in_rd  input  5  destination register tag.
REQ-009 Port: in_trap_en  input  1  overflow on this result SHALL raise a trap (signed add/sub).
REQ-010 Port: out_valid  output  1  buffered result available.
REQ-011 Port: out_ready  input  1  consumer accepts the head result.
REQ-012 Port: out_z  output  32;  out_overflow, out_zero, out_carryout  output  1 each;  out_rd  output  5  head entry fields.
REQ-013 Port: trap  output  1  one-cycle overflow-trap pulse;  trap_rd  output  5  tag of the trapped result.
REQ-014 Port: status_clr  input  1  clears sticky status.
REQ-015 Port: status  output  3  sticky {overflow, carryout, zero-seen} bits [2:0].

Function
REQ-016 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-017 in_ready SHALL be 1 iff occupancy < DEPTH and rst is low; it SHALL NOT depend on out_ready (no combinational ready path).
REQ-018 out_valid SHALL be 1 iff occupancy > 0; out_* SHALL reflect the oldest entry and hold stable while out_valid && !out_ready.
REQ-019 Latency: a result pushed in cycle N SHALL first appear on out_* in cycle N+1; no same-cycle bypass.
REQ-020 Results SHALL leave in push order; read/write pointers SHALL wrap modulo DEPTH.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged; when full, push is impossible even if a pop occurs that cycle.
REQ-022 A pushed entry with in_overflow && in_trap_en SHALL NOT be stored; trap SHALL pulse high in cycle N+1 with trap_rd = in_rd, otherwise trap = 0 and trap_rd holds its last value.
REQ-023 A pushed entry with in_rd == 0 SHALL be stored with z = 0 and zero = 1; its overflow/carryout flags SHALL be stored unchanged.
REQ-024 status[2] SHALL set on any push with in_overflow (trapped or not), status[1] on any push with in_carryout, status[0] on any push with in_zero, using the raw input flags.
REQ-025 status bits SHALL clear on status_clr; a set condition in the same cycle as status_clr SHALL win.
REQ-026 Occupancy counter SHALL be log2(DEPTH)+1 bits and never exceed DEPTH or underflow.

Reset
REQ-027 While rst is high: occupancy = 0, out_valid = 0, in_ready = 0, trap = 0, trap_rd = 0, status = 0, pointers = 0.
REQ-028 Reset mid-operation SHALL discard all buffered entries and any pending trap; out_z/out_rd/flags SHALL read 0 after reset.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-030 Reset then push Z=0x0000_0005, rd=3, out_ready=1 -> out_valid=1 next cycle with out_z=0x5, out_rd=3; one cycle later out_valid=0.
REQ-031 DEPTH=2, out_ready=0, push 0xA,0xB,0xC on consecutive cycles -> in_ready=0 after the second push, 0xC not accepted; then out_ready=1 -> outputs 0xA then 0xB, in order.
REQ-032 Push in_overflow=1, in_trap_en=1, rd=7 -> trap=1 for exactly one cycle, trap_rd=7, out_valid stays 0, status[2]=1.
REQ-033 Push Z=0xFFFF_FFFF, rd=0 -> out_z=0, out_zero=1; status[0] remains 0.
REQ-034 With one entry buffered, push and pop in the same cycle -> occupancy stays 1, new entry at head next cycle; status_clr asserted with an in_carryout push -> status[1]=1.
REQ-035 Fill buffer, assert rst for one cycle -> out_valid=0, status=0, in_ready=0 during reset and 1 the cycle after.
